// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs,
// FSM state type, ALU op encoding and small datapath helpers.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd,
        StMemWr, StWbAlu, StWbMem, StBranch, StJump, StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluOr = 3'd3, AluSlt = 3'd4
    } alu_op_e;

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] res;
        case (op)
            AluSub:  res = a - b;
            AluAnd:  res = a & b;
            AluOr:   res = a | b;
            AluSlt:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: res = a + b;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// $0 always reads zero; synchronous reset clears every entry.
module mips_mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // Clear on reset, otherwise write any register except $0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FSM-sequenced datapath, one shared ALU and one
// unified valid/ready memory port. Optional feature macro: MIPS_MC_BNE_EN
// (adds bne; without it op 0x05 halts the core).
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic                  halted
);

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << MEM_ADDR_W) - 64'd1);

    state_e      state;
    state_e      dec_next;
    alu_op_e     r_op;
    logic [31:0] ir, reg_a, reg_b, alu_out, mdr, br_target;
    logic [31:0] rf_rd1, rf_rd2, rf_wd, addr_sel, imm_sext;
    logic [4:0]  rf_wa;
    logic        rf_we, br_taken;

    wire [5:0] op    = ir[31:26];
    wire [4:0] rs    = ir[25:21];
    wire [4:0] rt    = ir[20:16];
    wire [4:0] rd    = ir[15:11];
    wire [5:0] funct = ir[5:0];
    assign imm_sext = sext16(ir[15:0]);

    mips_mc_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    // Opcode/funct dispatch out of DECODE; anything unrecognised halts.
    always_comb begin
        dec_next = StHalt;
        r_op     = AluAdd;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec_next = StExecR;
                    FN_SUB:  begin dec_next = StExecR; r_op = AluSub; end
                    FN_AND:  begin dec_next = StExecR; r_op = AluAnd; end
                    FN_OR:   begin dec_next = StExecR; r_op = AluOr;  end
                    FN_SLT:  begin dec_next = StExecR; r_op = AluSlt; end
                    FN_JR:   dec_next = StJump;
                    default: dec_next = StHalt;
                endcase
            end
            OP_ADDI, OP_SLTI: dec_next = StExecI;
            OP_LW, OP_SW:     dec_next = StMemAddr;
            OP_BEQ:           dec_next = StBranch;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:           dec_next = StBranch;
`endif
            OP_J, OP_JAL:     dec_next = StJump;
            default:          dec_next = StHalt;
        endcase
    end

    // Branch condition; bne only reaches BRANCH when the feature is built in.
`ifdef MIPS_MC_BNE_EN
    assign br_taken = (op == OP_BNE) ? (reg_a != reg_b) : (reg_a == reg_b);
`else
    assign br_taken = (reg_a == reg_b);
`endif

    // Register write port selection per write-back state.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = alu_out;
        case (state)
            StWbAlu: begin
                rf_we = 1'b1;
                rf_wa = (op == OP_RTYPE) ? rd : rt;
            end
            StWbMem: begin
                rf_we = 1'b1;
                rf_wd = mdr;
            end
            StJump: begin
                if (op == OP_JAL) begin
                    rf_we = 1'b1;
                    rf_wa = 5'd31;
                    rf_wd = pc;
                end
            end
            default: ;
        endcase
    end

    // Memory controls decode straight from state; reset drops any request.
    assign addr_sel  = (state == StFetch) ? pc : alu_out;
    assign mem_addr  = rst ? RESET_PC[MEM_ADDR_W-1:0] : addr_sel[MEM_ADDR_W-1:0];
    assign mem_re    = !rst && ((state == StFetch) || (state == StMemRd));
    assign mem_we    = !rst && (state == StMemWr);
    assign mem_wdata = reg_b;
    assign halted    = !rst && (state == StHalt);

    // Main FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StFetch;
            pc        <= RESET_PC & ADDR_MASK;
            ir        <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            br_target <= '0;
        end else begin
            case (state)
                StFetch: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= (pc + 32'd4) & ADDR_MASK;
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    reg_a     <= rf_rd1;
                    reg_b     <= rf_rd2;
                    br_target <= (pc + {imm_sext[29:0], 2'b00}) & ADDR_MASK;
                    state     <= dec_next;
                end
                StExecR: begin
                    alu_out <= alu(r_op, reg_a, reg_b);
                    state   <= StWbAlu;
                end
                StExecI: begin
                    alu_out <= alu((op == OP_SLTI) ? AluSlt : AluAdd, reg_a, imm_sext);
                    state   <= StWbAlu;
                end
                StMemAddr: begin
                    alu_out <= alu(AluAdd, reg_a, imm_sext) & ADDR_MASK & ~32'h3;
                    state   <= (op == OP_LW) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    if (mem_ready) begin
                        mdr   <= mem_rdata;
                        state <= StWbMem;
                    end
                end
                StMemWr: begin
                    if (mem_ready) state <= StFetch;
                end
                StWbAlu, StWbMem: state <= StFetch;
                StBranch: begin
                    if (br_taken) pc <= br_target;
                    state <= StFetch;
                end
                StJump: begin
                    if (op == OP_RTYPE) pc <= reg_a & ADDR_MASK;
                    else                pc <= {pc[31:28], ir[25:0], 2'b00} & ADDR_MASK;
                    state <= StFetch;
                end
                StHalt:  state <= StHalt;
                default: state <= StHalt;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed self-checking bench for mips_multicycle_core with a small memory
// model. Wait states are applied only to data accesses (not to fetches).
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_re, mem_we, mem_ready, halted;

    logic [31:0] mem [128];
    logic        clr = 1'b0, ld_en = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;
    int          wait_data = 0;
    int          wcnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic        data_req;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

    mips_multicycle_core #(
        .RESET_PC   (32'h0000_0100),
        .MEM_ADDR_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign data_req  = mem_we || (mem_re && (mem_addr != pc));
    assign mem_ready = (mem_re || mem_we) && (data_req ? (wcnt >= wait_data) : 1'b1);
    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            wr_cnt <= 0;
        end else if (ld_en) begin
            mem[ld_addr[8:2]] <= ld_data;
        end else if (mem_we && mem_ready) begin
            mem[mem_addr[8:2]] <= mem_wdata;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
        end
        if (rst || !(mem_re || mem_we) || mem_ready) wcnt <= 0;
        else                                         wcnt <= wcnt + 1;
    end

    task automatic start_load();
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_fetch(input logic [31:0] target, output int cnt);
        cnt = 0;
        while (!(mem_re && mem_addr == target) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 300) begin
            checks++;
            failures++;
            $display("FAIL wait_fetch: no fetch of %h within %0d cycles", target, cnt);
        end
    endtask

    task automatic test_reset();
        start_load();
        load_word(32'h100, 32'h2001_0005);
        load_word(32'h104, HALT_INSN);
        checks += 5;
        if (mem_re !== 1'b0) begin failures++; $display("FAIL rst_re got %b want 0", mem_re); end
        if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", mem_we); end
        if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b want 0", halted); end
        if (pc !== 32'h100) begin failures++; $display("FAIL rst_pc got %h want 100", pc); end
        if (mem_addr !== 32'h100) begin
            failures++; $display("FAIL rst_addr got %h want 100", mem_addr);
        end
        release_rst();
        checks++;
        if (!(mem_re === 1'b1 && mem_addr === 32'h100)) begin
            failures++; $display("FAIL first_fetch re=%b addr=%h want 1/100", mem_re, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'h104) begin failures++; $display("FAIL pc_after_fetch got %h want 104", pc); end
    endtask

    task automatic test_reset_mid();
        int c;
        start_load();
        load_word(32'h100, 32'h2001_0005);  // addi $1,$0,5
        load_word(32'h104, 32'hAC01_0008);  // sw $1,8($0)
        wait_data = 3;
        release_rst();
        c = 0;
        while (!mem_we && c < 50) begin @(negedge clk); c++; end
        checks++;
        if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_we_seen got %b want 1", mem_we); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_we_drop got %b want 0", mem_we); end
        if (mem_re !== 1'b0) begin failures++; $display("FAIL mid_re_drop got %b want 0", mem_re); end
        @(negedge clk);
        checks += 3;
        if (pc !== 32'h100) begin failures++; $display("FAIL mid_pc got %h want 100", pc); end
        if (wr_cnt !== 0) begin failures++; $display("FAIL mid_nowrite got %0d want 0", wr_cnt); end
        if (dut.u_regfile.regs[1] !== 32'd0) begin
            failures++; $display("FAIL mid_gpr_clr got %h want 0", dut.u_regfile.regs[1]);
        end
        wait_data = 0;
    endtask

    task automatic test_alu_prog();
        int c;
        start_load();
        load_word(32'h100, 32'h2001_0005);  // addi $1,$0,5
        load_word(32'h104, 32'h2002_FFFD);  // addi $2,$0,-3
        load_word(32'h108, 32'h0041_182A);  // slt  $3,$2,$1
        load_word(32'h10C, 32'h0022_2020);  // add  $4,$1,$2
        load_word(32'h110, HALT_INSN);
        release_rst();
        wait_fetch(32'h110, c);
        checks += 5;
        if (c !== 16) begin failures++; $display("FAIL alu_cycles got %0d want 16", c); end
        if (dut.u_regfile.regs[1] !== 32'd5) begin
            failures++; $display("FAIL r1 got %h want 5", dut.u_regfile.regs[1]);
        end
        if (dut.u_regfile.regs[2] !== 32'hFFFF_FFFD) begin
            failures++; $display("FAIL r2 got %h want fffffffd", dut.u_regfile.regs[2]);
        end
        if (dut.u_regfile.regs[3] !== 32'd1) begin
            failures++; $display("FAIL slt_r3 got %h want 1", dut.u_regfile.regs[3]);
        end
        if (dut.u_regfile.regs[4] !== 32'd2) begin
            failures++; $display("FAIL add_r4 got %h want 2", dut.u_regfile.regs[4]);
        end
    endtask

    task automatic test_mem();
        int c;
        start_load();
        load_word(32'h100, 32'h2001_0005);  // addi $1,$0,5
        load_word(32'h104, 32'hAC01_0008);  // sw $1,8($0)
        load_word(32'h108, 32'h8C05_0008);  // lw $5,8($0)
        load_word(32'h10C, HALT_INSN);
        wait_data = 2;
        release_rst();
        wait_fetch(32'h104, c);
        wait_fetch(32'h10C, c);
        checks += 5;
        if (c !== 13) begin failures++; $display("FAIL swlw_cycles got %0d want 13", c); end
        if (wr_cnt !== 1) begin failures++; $display("FAIL sw_count got %0d want 1", wr_cnt); end
        if (wr_addr !== 32'd8) begin failures++; $display("FAIL sw_addr got %h want 8", wr_addr); end
        if (wr_data !== 32'd5) begin failures++; $display("FAIL sw_data got %h want 5", wr_data); end
        if (dut.u_regfile.regs[5] !== 32'd5) begin
            failures++; $display("FAIL lw_r5 got %h want 5", dut.u_regfile.regs[5]);
        end
        wait_data = 0;
    endtask

    task automatic test_branch();
        int c;
        start_load();
        load_word(32'h100, 32'h1000_FFFF);  // beq $0,$0,-1
        release_rst();
        @(negedge clk);
        wait_fetch(32'h100, c);
        checks += 2;
        if (c !== 2) begin failures++; $display("FAIL beq_loop_cycles got %0d want 2", c); end
        if (pc !== 32'h100) begin failures++; $display("FAIL beq_loop_pc got %h want 100", pc); end
        start_load();
        load_word(32'h100, 32'h2001_0005);  // addi $1,$0,5
        load_word(32'h104, 32'h1020_0004);  // beq $1,$0,+4 (not taken)
        load_word(32'h108, HALT_INSN);
        release_rst();
        wait_fetch(32'h104, c);
        wait_fetch(32'h108, c);
        checks++;
        if (c !== 3) begin failures++; $display("FAIL beq_nt_cycles got %0d want 3", c); end
    endtask

    task automatic test_jump();
        int c;
        start_load();
        load_word(32'h100, 32'h0800_0008);  // j 0x20
        load_word(32'h020, 32'h0C00_000C);  // jal 0x30
        load_word(32'h030, 32'h03E0_0008);  // jr $31
        load_word(32'h024, HALT_INSN);
        release_rst();
        wait_fetch(32'h020, c);
        checks++;
        if (c !== 3) begin failures++; $display("FAIL j_cycles got %0d want 3", c); end
        wait_fetch(32'h030, c);
        checks += 2;
        if (c !== 3) begin failures++; $display("FAIL jal_cycles got %0d want 3", c); end
        if (dut.u_regfile.regs[31] !== 32'h24) begin
            failures++; $display("FAIL jal_r31 got %h want 24", dut.u_regfile.regs[31]);
        end
        wait_fetch(32'h024, c);
        checks++;
        if (c !== 3) begin failures++; $display("FAIL jr_cycles got %0d want 3", c); end
    endtask

    task automatic test_halt();
        int reqs;
        start_load();
        load_word(32'h100, HALT_INSN);
        release_rst();
        @(negedge clk);
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_decode got %b want 0", halted); end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_rise got %b want 1", halted); end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_re || mem_we) reqs++;
        end
        checks += 2;
        if (reqs !== 0) begin failures++; $display("FAIL halt_noreq got %0d want 0", reqs); end
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_stay got %b want 1", halted); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_clr got %b want 0", halted); end
        rst = 1'b0;
        #1;
        checks++;
        if (!(mem_re === 1'b1 && mem_addr === 32'h100)) begin
            failures++; $display("FAIL halt_restart re=%b addr=%h want 1/100", mem_re, mem_addr);
        end
    endtask

    task automatic test_bne();
        int c;
        start_load();
        load_word(32'h100, 32'h2001_0005);  // addi $1,$0,5
        load_word(32'h104, 32'h1420_0002);  // bne $1,$0,+2 -> 0x110
        load_word(32'h108, HALT_INSN);
        load_word(32'h110, HALT_INSN);
        release_rst();
        wait_fetch(32'h104, c);
`ifdef MIPS_MC_BNE_EN
        wait_fetch(32'h110, c);
        checks++;
        if (c !== 3) begin failures++; $display("FAIL bne_taken_cycles got %0d want 3", c); end
`else
        repeat (3) @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL bne_illegal got %b want 1", halted); end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_alu_prog();
        test_mem();
        test_branch();
        test_jump();
        test_halt();
        test_bne();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle MIPS core: one FSM-sequenced datapath sharing a single ALU and a single external unified instruction/data memory port. The memory port uses a valid/ready handshake, so the core tolerates memory wait states. Next generation of the single-cycle datapath: same instruction subset, parametrised reset vector and address width, plus an illegal-opcode halt. Sits between the testbench/top level and the memory model.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- MEM_ADDR_W, 32: width of mem_addr; the PC and byte addresses are truncated to this width.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- mem_addr  out  MEM_ADDR_W  byte address, bits [1:0] always 0.
- mem_re  out  1  read request.
- mem_we  out  1  write request; never asserted together with mem_re.
- mem_wdata  out  32  store data (rt value).
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  completes the pending request at this edge; ignored when there is no request.
- pc  out  32  architectural PC (debug).
- halted  out  1  core stopped on an illegal instruction.

## Operation
- Supported instructions:
  - R-type (op 0x00): funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I-type: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02, jal 0x03.
- Any other op/funct combination → HALT.
- FSM states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
- State transitions:
  - FETCH: drive mem_re=1 and mem_addr=pc. On mem_ready, latch IR←mem_rdata and pc←pc+4, then go to DECODE. Otherwise hold.
  - DECODE: read rs/rt into A/B. Compute branch target = pc + (sext(imm)<<2), where pc is already pc+4. Dispatch on opcode.
  - EXEC_R / EXEC_I: ALU result → ALUOut, then WB_ALU.
  - WB_ALU: write to rd (R-type) or rt (I-type), then FETCH.
  - MEM_ADDR: ALUOut = A + sext(imm), with bits [1:0] cleared. Go to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_re=1 until mem_ready; latch MDR, then WB_MEM.
  - WB_MEM: rt←MDR, then FETCH.
  - MEM_WR: mem_we=1 and mem_wdata=B until mem_ready, then FETCH.
  - BRANCH (beq): if A==B, pc←target. Then FETCH.
  - JUMP:
    - j: pc←{pc[31:28], IR[25:0], 2'b00}.
    - jal: additionally $31←pc (already pc+4).
    - jr: pc←A.
    - Then FETCH.
  - HALT: absorbing; halted=1, no memory requests. Leave only via rst.
- Immediate handling:
  - addi and slti sign-extend the immediate.
  - slt and slti compare signed 32-bit values; result is 32'd0 or 32'd1.
  - add, sub and addi wrap modulo 2^32; no overflow trap.
- Register file:
  - 32×32.
  - $0 reads 0; writes to $0 are discarded.
  - Read-before-write within a cycle: the old value is returned.
- rst mid-operation:
  - Any pending request is abandoned; mem_re and mem_we drop in the reset cycle.
  - pc←RESET_PC, state←FETCH, all GPRs←0.

## Timing
- Reset values (asserted while rst=1, and in the following cycle until state logic acts): mem_re=0, mem_we=0, halted=0, pc=RESET_PC, mem_addr=RESET_PC.
- Memory control outputs are combinational from state. The address is stable for the entire request.
- Cycles per instruction with zero wait states (mem_ready=1 in the first request cycle):
  - R-type and addi/slti: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
- Each wait cycle adds 1 cycle.
- Register writes and the PC update take effect at the edge that leaves the state.
- First fetch request occurs in the first cycle after rst is released.
- When halted, halted rises in the cycle after DECODE.

## Configuration
- MIPS_MC_BNE_EN:
  - When defined: bne (op 0x05) is decoded and handled in BRANCH, taken if A!=B.
  - When undefined: op 0x05 is illegal and leads to HALT.

## Structure
- Package mips_mc_pkg holds:
  - Opcode and funct localparams.
  - The state enum type.
  - The 3-bit ALU op encoding (ADD, SUB, AND, OR, SLT).
- One sub-module, mips_mc_regfile: 2 read ports, 1 write port, synchronous reset clears all entries.
- ALU, muxes and FSM live in the top module.

## Test plan
- Reset with RESET_PC=32'h100 → first mem_re has mem_addr=32'h100; pc=32'h104 after the fetch.
- Program addi $1,$0,5; addi $2,$0,-3; slt $3,$2,$1; add $4,$1,$2:
  - Final register values: $3=1, $4=2.
  - Total cycle count 16 with zero wait states.
- sw $1,8($0) then lw $5,8($0):
  - mem_we is asserted with addr 8 and wdata 5.
  - $5=5.
  - With 2 wait states on each access, the pair takes 13 cycles.
- beq taken with offset -1 → PC loops on itself. jal at 0x20 → $31=0x24; jr $31 returns to 0x24.
- Opcode 0x3F → halted=1; no further mem_re. Asserting rst clears halted and restarts fetch at RESET_PC.
- bne $1,$0,+2 with $1≠0:
  - With MIPS_MC_BNE_EN defined: branch is taken.
  - Without it: halted=1.
